// File: rtl/axi_rt_req_arbiter_if.sv
// Bundle of requester-side and AXI manager-side signals for axi_rt_req_arbiter.
// The master modport is the arbiter's view; slave is the view of whatever
// sits around it (requesters plus the AXI subordinate).
interface axi_rt_req_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   localparam int STRB_W = DATA_WIDTH / 8;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ*STRB_W-1:0]     req_wstrb;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic [1:0]                    rsp_resp;
   logic                          busy;

   logic                  awvalid, awready;
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  wvalid, wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_W-1:0]     wstrb;
   logic                  wlast;
   logic                  bvalid, bready;
   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  arvalid, arready;
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  rvalid, rready;
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output req_ready, rsp_valid, rsp_rdata, rsp_resp, busy,
      output awvalid, awid, awaddr, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready,
      output arvalid, arid, araddr, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rid, rdata, rresp, rlast,
      output rready
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  req_ready, rsp_valid, rsp_rdata, rsp_resp, busy,
      input  awvalid, awid, awaddr, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready,
      input  arvalid, arid, araddr, arlen, arsize, arburst,
      output arready,
      output rvalid, rid, rdata, rresp, rlast,
      input  rready
   );
endinterface

// File: rtl/axi_rt_req_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI manager port between
// NUM_REQ register-access requesters, one transaction outstanding at a time.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no transaction; arbitrate and grant combinationally
// S_WR    | AW and W presented, each dropped after its own handshake
// S_WRESP | both AW and W accepted, waiting for B
// S_RD    | AR presented, waiting for arready
// S_RDATA | AR accepted, waiting for R
module axi_rt_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input logic                  aclk,
   input logic                  aresetn,
   axi_rt_req_arbiter_if.master bus
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;
   logic [IDX_W-1:0]      idx_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;
   logic [NUM_REQ-1:0]    rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic [1:0]            rsp_resp_q;
   logic [1:0]            rst_sync_q;
   logic                  rst_n;

   logic                  found, grant, b_hs, r_hs;
   logic [IDX_W-1:0]      win_idx;
   logic [IDX_W:0]        sum;
   logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
   logic [STRB_W-1:0]     wstrb_a [NUM_REQ];
   logic                  unused_ok;

   // Reset asserts immediately, releases two edges after aresetn rises.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rst_sync_q <= '0;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_a[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_a[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
      assign wstrb_a[g] = bus.req_wstrb[g*STRB_W +: STRB_W];
   end

   // Pick the first valid requester at or after the pointer, wrapping.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      sum     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
         if (!found && bus.req_valid[sum[IDX_W-1:0]]) begin
            found   = 1'b1;
            win_idx = sum[IDX_W-1:0];
         end
      end
   end

   assign grant = rst_n && (state_q == S_IDLE) && found;

   // Next-state and channel-valid sequencing.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      b_hs      = 1'b0;
      r_hs      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
               if (bus.req_write[win_idx]) begin
                  state_d   = S_WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RD;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_WR: begin
            if (awvalid_q && bus.awready) awvalid_d = 1'b0;
            if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d)  state_d   = S_WRESP;
         end
         S_WRESP: begin
            if (bus.bvalid) begin
               b_hs    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            if (bus.arready) begin
               arvalid_d = 1'b0;
               state_d   = S_RDATA;
            end
         end
         S_RDATA: begin
            if (bus.rvalid) begin
               r_hs    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state, pointer and channel valids.
   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
      end
   end

   // Capture the winner's payload at grant; register the completion pulse.
   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
      end else begin
         if (grant) begin
            idx_q   <= win_idx;
            addr_q  <= addr_a[win_idx] & ALIGN_MASK;
            wdata_q <= wdata_a[win_idx];
            wstrb_q <= wstrb_a[win_idx];
         end
         rsp_valid_q <= '0;
         if (b_hs || r_hs) begin
            rsp_valid_q <= NUM_REQ'(1) << idx_q;
            rsp_rdata_q <= r_hs ? bus.rdata : '0;
            rsp_resp_q  <= r_hs ? bus.rresp : bus.bresp;
         end
      end
   end

   // IDs and rlast carry no information with a single transaction in flight.
   assign unused_ok = ^{bus.bid, bus.rid, bus.rlast};

   assign bus.req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_resp  = rsp_resp_q;
   assign bus.busy      = (state_q != S_IDLE) || grant;

   assign bus.awvalid = awvalid_q;
   assign bus.awid    = ID_WIDTH'(idx_q);
   assign bus.awaddr  = addr_q;
   assign bus.awlen   = 8'h00;
   assign bus.awsize  = awvalid_q ? AXSIZE : 3'd0;
   assign bus.awburst = awvalid_q ? 2'b01 : 2'b00;
   assign bus.wvalid  = wvalid_q;
   assign bus.wdata   = wdata_q;
   assign bus.wstrb   = wstrb_q;
   assign bus.wlast   = wvalid_q;
   assign bus.bready  = (state_q == S_WRESP);
   assign bus.arvalid = arvalid_q;
   assign bus.arid    = ID_WIDTH'(idx_q);
   assign bus.araddr  = addr_q;
   assign bus.arlen   = 8'h00;
   assign bus.arsize  = arvalid_q ? AXSIZE : 3'd0;
   assign bus.arburst = arvalid_q ? 2'b01 : 2'b00;
   assign bus.rready  = (state_q == S_RDATA);
endmodule

// File: tb/tb_axi_rt_req_arbiter.sv
// Bench for axi_rt_req_arbiter: transaction-level model of the arbiter plus a
// delay-programmable AXI subordinate, directed scenarios then random traffic.
module tb_axi_rt_req_arbiter;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int IW = 4;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   axi_rt_req_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   axi_rt_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .aclk(aclk), .aresetn(aresetn), .bus(bus));

   int checks = 0;
   int errors = 0;

   // requester pool
   bit        rv [N];
   bit        rw [N];
   bit [15:0] ra [N];
   bit [31:0] rd [N];
   bit [3:0]  rs [N];

   // transaction-level model
   bit        rst_drv = 1'b0;
   bit        txn_active, t_wr, aw_done, w_done, ar_done;
   int        t_idx, ptr_m;
   bit [15:0] t_addr;
   bit [31:0] t_wdata;
   bit [3:0]  t_wstrb;
   bit        resp_due;
   int        resp_idx;
   bit [31:0] resp_data;
   bit [1:0]  resp_resp;

   // subordinate behaviour
   int        aw_dly, w_dly, ar_dly, b_dly, r_dly;
   int        aw_wait, w_wait, ar_wait, b_wait, r_wait;
   bit [1:0]  cfg_bresp, cfg_rresp;
   bit [31:0] cfg_rdata;
   bit        rand_mode, keep_valid;

   int        grant_log [$];
   int        cyc_n, grant_cyc, rsp_cyc, n_grant, n_rsp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_sub(input int a, input int w, input int ar, input int b, input int r);
      aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
   endtask

   // One clock: drive at negedge, compare 1ns later, then advance the model.
   task automatic cyc();
      bit exp_aw, exp_w, exp_ar, exp_br, exp_rr, idle, found, b_hs, r_hs;
      bit awr, wrr, arr, bv, rvv;
      bit [1:0] bresp_v, rresp_v;
      bit [31:0] rdata_v;
      int win;
      logic [N-1:0] exp_rdy, exp_rsp;
      @(negedge aclk);
      aresetn = rst_drv;
      if (!rst_drv) begin
         txn_active = 0; resp_due = 0; ptr_m = 0;
      end
      exp_aw = txn_active && t_wr && !aw_done;
      exp_w  = txn_active && t_wr && !w_done;
      exp_ar = txn_active && !t_wr && !ar_done;
      exp_br = txn_active && t_wr && aw_done && w_done;
      exp_rr = txn_active && !t_wr && ar_done;
      awr = exp_aw ? (aw_wait >= aw_dly) : 1'($urandom);
      wrr = exp_w  ? (w_wait  >= w_dly)  : 1'($urandom);
      arr = exp_ar ? (ar_wait >= ar_dly) : 1'($urandom);
      bv  = exp_br && (b_wait >= b_dly);
      rvv = exp_rr && (r_wait >= r_dly);
      bresp_v = bv  ? cfg_bresp : 2'($urandom);
      rresp_v = rvv ? cfg_rresp : 2'($urandom);
      rdata_v = rvv ? cfg_rdata : $urandom;
      bus.awready = awr; bus.wready = wrr; bus.arready = arr;
      bus.bvalid = bv; bus.bresp = bresp_v; bus.bid = IW'(t_idx);
      bus.rvalid = rvv; bus.rresp = rresp_v; bus.rdata = rdata_v;
      bus.rid = IW'(t_idx); bus.rlast = 1'b1;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i] = rv[i];
         bus.req_write[i] = rw[i];
         bus.req_addr[i*AW +: AW]  = ra[i];
         bus.req_wdata[i*DW +: DW] = rd[i];
         bus.req_wstrb[i*4 +: 4]   = rs[i];
      end
      #1;
      found = 0; win = 0;
      for (int k = 0; k < N; k++)
         if (!found && rv[(ptr_m + k) % N]) begin
            found = 1; win = (ptr_m + k) % N;
         end
      idx_check: begin end
      idle    = rst_drv && !txn_active;
      exp_rdy = (idle && found) ? (N'(1) << win) : '0;
      exp_rsp = resp_due ? (N'(1) << resp_idx) : '0;
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("busy", bus.busy, txn_active || (idle && found));
      chk("rsp_valid", bus.rsp_valid, exp_rsp);
      if (resp_due) begin
         chk("rsp_rdata", bus.rsp_rdata, resp_data);
         chk("rsp_resp", bus.rsp_resp, resp_resp);
         rsp_cyc = cyc_n;
      end
      chk("awvalid", bus.awvalid, exp_aw);
      chk("wvalid", bus.wvalid, exp_w);
      chk("arvalid", bus.arvalid, exp_ar);
      chk("bready", bus.bready, exp_br);
      chk("rready", bus.rready, exp_rr);
      if (exp_aw) begin
         chk("awid", bus.awid, t_idx);
         chk("awaddr", bus.awaddr, {t_addr[15:2], 2'b00});
         chk("awlen", bus.awlen, 0);
         chk("awsize", bus.awsize, 2);
         chk("awburst", bus.awburst, 1);
      end
      if (exp_w) begin
         chk("wdata", bus.wdata, t_wdata);
         chk("wstrb", bus.wstrb, t_wstrb);
         chk("wlast", bus.wlast, 1);
      end
      if (exp_ar) begin
         chk("arid", bus.arid, t_idx);
         chk("araddr", bus.araddr, {t_addr[15:2], 2'b00});
         chk("arlen", bus.arlen, 0);
         chk("arsize", bus.arsize, 2);
         chk("arburst", bus.arburst, 1);
      end
      if (!rst_drv) begin
         chk("rst_payload", {bus.awaddr, bus.araddr, bus.awid, bus.arid, bus.wstrb, bus.wlast,
                             bus.awsize, bus.arsize, bus.awburst, bus.arburst, bus.rsp_resp}, 0);
         chk("rst_data", {bus.wdata, bus.rsp_rdata}, 0);
      end
      b_hs = exp_br && bv;
      r_hs = exp_rr && rvv;
      resp_due = 0;
      if (b_hs || r_hs) begin
         resp_due  = 1;
         resp_idx  = t_idx;
         resp_data = r_hs ? rdata_v : 32'h0;
         resp_resp = b_hs ? bresp_v : rresp_v;
         txn_active = 0;
         n_rsp++;
      end
      if (exp_aw) begin if (awr) aw_done = 1; else aw_wait++; end
      if (exp_w)  begin if (wrr) w_done = 1;  else w_wait++;  end
      if (exp_ar) begin if (arr) ar_done = 1; else ar_wait++; end
      if (exp_br && !bv)  b_wait++;
      if (exp_rr && !rvv) r_wait++;
      if (exp_rdy != '0) begin
         txn_active = 1;
         t_idx = win; t_wr = rw[win]; t_addr = ra[win]; t_wdata = rd[win]; t_wstrb = rs[win];
         aw_done = 0; w_done = 0; ar_done = 0;
         aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
         ptr_m = (win + 1) % N;
         grant_log.push_back(win);
         grant_cyc = cyc_n;
         n_grant++;
         if (!keep_valid) rv[win] = 0;
         if (rand_mode) begin
            set_sub($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            cfg_bresp = 2'($urandom); cfg_rresp = 2'($urandom); cfg_rdata = $urandom;
         end
      end
      if (rand_mode)
         for (int i = 0; i < N; i++)
            if (!rv[i] && $urandom_range(0, 2) == 0) begin
               rv[i] = 1; rw[i] = 1'($urandom); ra[i] = 16'($urandom);
               rd[i] = $urandom; rs[i] = 4'($urandom);
            end
      cyc_n++;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) rv[i] = 0;
   endtask

   task automatic drain();
      clear_reqs();
      keep_valid = 0;
      for (int c = 0; c < 200 && (txn_active || resp_due); c++) cyc();
      chk("drain_timeout", txn_active || resp_due, 0);
   endtask

   task automatic set_req(input int i, input bit w, input bit [15:0] a,
                          input bit [31:0] d, input bit [3:0] s);
      rv[i] = 1; rw[i] = w; ra[i] = a; rd[i] = d; rs[i] = s;
   endtask

   initial begin
      int g0, r0;
      clear_reqs();
      set_sub(0, 0, 0, 0, 0);
      cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
      rand_mode = 0; keep_valid = 0; ptr_m = 0;

      // reset state
      rst_drv = 0;
      repeat (3) cyc();
      rst_drv = 1;
      repeat (3) cyc();

      // round-robin with all requesters continuously valid
      keep_valid = 1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'(16'h0200 + 16'(i * 4)), 32'h0, 4'h0);
      cfg_rdata = 32'hA5A5_0001;
      grant_log.delete();
      for (int c = 0; c < 40 && grant_log.size() < 5; c++) cyc();
      keep_valid = 0;
      clear_reqs();
      chk("rr_count", grant_log.size(), 5);
      if (grant_log.size() == 5)
         for (int k = 0; k < 5; k++) chk("rr_order", grant_log[k], k % N);
      drain();

      // single write from requester 2
      set_sub(0, 0, 0, 0, 0);
      cfg_bresp = 0;
      set_req(2, 1'b1, 16'h0012, 32'hDEADBEEF, 4'hF);
      cyc();
      chk("wr_grant", bus.req_ready, 4'b0100);
      cyc();
      chk("wr_awid", bus.awid, 2);
      chk("wr_awaddr", bus.awaddr, 16'h0010);
      chk("wr_awsize", bus.awsize, 2);
      chk("wr_wlast", bus.wlast, 1);
      chk("wr_wdata", bus.wdata, 32'hDEADBEEF);
      repeat (2) cyc();
      chk("wr_rsp_valid", bus.rsp_valid, 4'b0100);
      chk("wr_rsp_resp", bus.rsp_resp, 0);
      chk("wr_latency", rsp_cyc - grant_cyc, 3);
      drain();

      // read from requester 1
      cfg_rdata = 32'h12345678; cfg_rresp = 2'b10;
      set_req(1, 1'b0, 16'h0100, 32'h0, 4'h0);
      cyc();
      cyc();
      chk("rd_arid", bus.arid, 1);
      chk("rd_araddr", bus.araddr, 16'h0100);
      repeat (2) cyc();
      chk("rd_rsp_valid", bus.rsp_valid, 4'b0010);
      chk("rd_rsp_rdata", bus.rsp_rdata, 32'h12345678);
      chk("rd_rsp_resp", bus.rsp_resp, 2);
      drain();

      // AW accepted three cycles late, W immediately
      set_sub(3, 0, 0, 0, 0);
      cfg_bresp = 2'b01;
      set_req(3, 1'b1, 16'h0ABE, 32'h0BAD_F00D, 4'h6);
      cyc();
      cyc();
      chk("split_w_t1", bus.wvalid, 1);
      cyc();
      chk("split_w_t2", bus.wvalid, 0);
      chk("split_aw_t2", bus.awvalid, 1);
      chk("split_addr_t2", bus.awaddr, 16'h0ABC);
      chk("split_bready_t2", bus.bready, 0);
      repeat (2) cyc();
      chk("split_aw_t4", bus.awvalid, 1);
      chk("split_bready_t4", bus.bready, 0);
      cyc();
      chk("split_bready_t5", bus.bready, 1);
      drain();

      // AR and R backpressure with a competing requester waiting
      set_sub(0, 0, 5, 0, 4);
      cfg_rdata = 32'hCAFE_0042; cfg_rresp = 2'b00;
      grant_log.delete();
      set_req(0, 1'b0, 16'h3007, 32'h0, 4'h0);
      set_req(1, 1'b0, 16'h4000, 32'h0, 4'h0);
      cyc();
      for (int c = 0; c < 10; c++) begin
         cyc();
         chk("bp_busy", bus.busy, 1);
         chk("bp_no_grant", bus.req_ready, 0);
      end
      clear_reqs();
      drain();
      chk("bp_grants", grant_log.size(), 1);

      // reset while waiting for B
      set_sub(0, 0, 0, 10, 0);
      set_req(0, 1'b1, 16'h0044, 32'h1111_2222, 4'h3);
      repeat (3) cyc();
      chk("mr_in_wresp", bus.bready, 1);
      clear_reqs();
      rst_drv = 0;
      cyc();
      chk("mr_busy", bus.busy, 0);
      chk("mr_bready", bus.bready, 0);
      cyc();
      rst_drv = 1;
      repeat (3) cyc();
      chk("mr_no_rsp", bus.rsp_valid, 0);
      set_sub(0, 0, 0, 0, 0);
      set_req(0, 1'b0, 16'h0010, 32'h0, 4'h0);
      set_req(1, 1'b0, 16'h0020, 32'h0, 4'h0);
      cyc();
      chk("mr_first_grant", bus.req_ready, 4'b0001);
      drain();

      // random traffic
      g0 = n_grant; r0 = n_rsp;
      rand_mode = 1;
      repeat (1500) cyc();
      rand_mode = 0;
      drain();
      chk("rand_completions", n_rsp - r0, n_grant - g0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/axi_rt_req_arbiter.md
Name: axi_rt_req_arbiter

Overview:
- Shares one AXI5 manager port between NUM_REQ simple register-access requesters.
- Port is configured for regular transactions only: single beat, INCR, full-width, aligned.
- Round-robin arbitration with exactly one transaction outstanding at a time.
- Typical use: control-plane CPU and DMA-descriptor engines sharing one AXI peripheral bus (16-bit address, 32-bit data, 4-bit IDs).

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 16, AXI address width.
- DATA_WIDTH, 32, AXI data width (32 or 64).
- ID_WIDTH, 4, AXI ID width; must be >= clog2(NUM_REQ).

Ports:
- aclk  in  1  single clock; all logic rises on posedge.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed byte addresses.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed write strobes.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_resp  out  2  BRESP/RRESP of completed transaction.
- busy  out  1  transaction in flight.
- awvalid/awready  out/in  1  AW handshake.
- awid  out  ID_WIDTH  granted requester index.
- awaddr  out  ADDR_WIDTH  aligned address.
- awlen  out  8  constant 0.
- awsize  out  3  constant log2(DATA_WIDTH/8).
- awburst  out  2  constant INCR (2'b01).
- wvalid/wready  out/in  1  W handshake.
- wdata  out  DATA_WIDTH  write data.
- wstrb  out  DATA_WIDTH/8  write strobe.
- wlast  out  1  constant 1 whenever wvalid.
- bvalid/bready  in/out  1  B handshake.
- bid  in  ID_WIDTH  write response ID.
- bresp  in  2  write response.
- arvalid/arready  out/in  1  AR handshake.
- arid, araddr, arlen, arsize, arburst  out  as AW  read address fields; same constants.
- rvalid/rready  in/out  1  R handshake.
- rid, rdata, rresp, rlast  in  ID_WIDTH, DATA_WIDTH, 2, 1  read data.

Behaviour:
- Reset (async assert, deassertion synchronised to aclk):
  - All outputs 0; FSM=IDLE; round-robin pointer=0.
  - Reset mid-transaction abandons it; no rsp_valid is issued.
- FSM states: IDLE, WR (AW+W), WRESP, RD (AR), RDATA.
- Arbitration (IDLE only):
  - Winner is the first asserted req_valid at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in that cycle; the handshake captures write/addr/wdata/wstrb and the index.
  - Pointer becomes winner+1 (wraps to 0 after NUM_REQ-1).
  - Next state: WR if write, else RD. No req_valid: stay in IDLE.
- Address handling: low log2(DATA_WIDTH/8) bits of awaddr/araddr are forced to 0.
- WR state:
  - awvalid and wvalid rise the cycle after grant.
  - Each drops independently after its own handshake; the two may complete in any order or in the same cycle.
  - Move to WRESP once both have completed.
  - Once raised, valid and payload hold stable until accepted.
- WRESP: bready=1. On bvalid, latch bresp and go to IDLE.
- RD state: arvalid from the cycle after grant until the arready handshake, then RDATA.
- RDATA: rready=1. On rvalid, latch rdata/rresp and go to IDLE. rlast is ignored (always 1 for legal subordinates).
- Completion:
  - rsp_valid[index] pulses the cycle after the B or R handshake, with rsp_rdata (0 for writes) and rsp_resp.
  - IDLE may grant a new request in that same cycle.
  - No backpressure on responses.
- busy=1 from the grant cycle through the B/R handshake cycle.
- Minimum latency with always-ready subordinate and same-cycle response: grant at T0, AW/W at T1, B at T2, rsp_valid at T3. Reads follow the same timing.
- bid/rid are not checked by RTL; single-outstanding operation guarantees a match.

Test Plan:
- Single write: req 2 writes addr 0x0012, wdata 0xDEADBEEF, wstrb 0xF; subordinate always ready.
  -> awid=2, awaddr=0x0010, awlen=0, awsize=2, awburst=1, wlast=1 at T1; rsp_valid=4'b0100 and rsp_resp=0 at T3.
- Read: req 1 reads 0x0100; rdata=0x12345678, rresp=2'b10.
  -> arid=1; rsp_rdata=0x12345678, rsp_resp=2 and rsp_valid=4'b0010 one cycle after the R handshake.
- Round-robin: all 4 requesters valid continuously.
  -> grants 0,1,2,3,0 in order; no requester granted twice before the others.
- Split AW/W: awready delayed 3 cycles, wready immediate.
  -> wvalid drops after 1 cycle; awvalid and awaddr held stable; bready asserted only after both handshakes.
- Backpressure: arready low 5 cycles, then rvalid delayed 4 cycles.
  -> arvalid/araddr stable throughout; busy=1 the whole time; no second grant.
- Reset mid-transaction: assert aresetn=0 during WRESP.
  -> all outputs 0 immediately; no rsp_valid; first grant after reset goes to req 0.
